// File: rtl/rv32ima_pkg.sv
// rv32ima_pkg: shared RV32IMA widths and types, including the writeback arbiter defaults.
package rv32ima_pkg;
    localparam int REG_W      = 5;
    localparam int WORD_W     = 32;
    localparam int NUM_WB_REQ = 3;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regsel_t;
endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// rr_arbiter: one-hot grant searching from ptr upward with wrap-around.
// With RF_WB_FIXED_PRIO_EN defined there is no ptr input and the lowest index wins.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
`ifndef RF_WB_FIXED_PRIO_EN
    input  logic [PW-1:0] ptr,
`endif
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);
    int j;
    // Scan from lowest priority to highest so the last hit is the winner.
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
`ifdef RF_WB_FIXED_PRIO_EN
            j = k;
`else
            j = (int'(ptr) + k) % N;
`endif
            if (en && req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = j[PW-1:0];
            end
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the regfile write port among NUM_REQ writeback requesters through one output stage.
// RF_WB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module rf_wb_arbiter
    import rv32ima_pkg::*;
#(
    parameter int NUM_REQ = rv32ima_pkg::NUM_WB_REQ,
    parameter int REG_W   = rv32ima_pkg::REG_W,
    parameter int WORD_W  = rv32ima_pkg::WORD_W
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][REG_W-1:0]   req_sel,
    input  logic [NUM_REQ-1:0][WORD_W-1:0]  req_dat,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            hold,
    output logic                            wen,
    output logic [REG_W-1:0]                wsel,
    output logic [WORD_W-1:0]               wdat,
    output logic                            pend_valid,
    output logic [REG_W-1:0]                pend_sel
);
    localparam int PW = $clog2(NUM_REQ);

    logic               out_valid_q, out_valid_d;
    logic [REG_W-1:0]   out_sel_q, out_sel_d;
    logic [WORD_W-1:0]  out_dat_q, out_dat_d;
    logic [NUM_REQ-1:0] gnt;
    logic [PW-1:0]      gidx;
    logic               drain, can_accept, hit, load;
`ifndef RF_WB_FIXED_PRIO_EN
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
`endif

    assign drain      = out_valid_q & ~hold;
    // Gated by nrst so no handshake can complete while reset is held.
    assign can_accept = (~out_valid_q | ~hold) & nrst;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .req (req_valid),
`ifndef RF_WB_FIXED_PRIO_EN
        .ptr (rr_ptr_q),
`endif
        .en  (can_accept),
        .gnt (gnt),
        .idx (gidx)
    );

    assign req_ready  = gnt;
    assign hit        = |gnt;
    assign load       = hit & (req_sel[gidx] != '0);
    assign wen        = drain;
    assign wsel       = out_sel_q;
    assign wdat       = out_dat_q;
    assign pend_valid = out_valid_q;
    assign pend_sel   = out_sel_q;

    // Writes to x0 complete the handshake but never occupy the stage.
    always_comb begin
        out_valid_d = load | (out_valid_q & ~drain);
        out_sel_d   = load ? req_sel[gidx] : out_sel_q;
        out_dat_d   = load ? req_dat[gidx] : out_dat_q;
`ifndef RF_WB_FIXED_PRIO_EN
        rr_ptr_d    = hit ? ((gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1) : rr_ptr_q;
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            out_dat_q   <= '0;
`ifndef RF_WB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            out_dat_q   <= out_dat_d;
`ifndef RF_WB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed stimulus with grant and write scoreboards checked by negedge monitors.
module tb_rf_wb_arbiter;
    localparam int N = 3;

    logic              clk = 1'b0;
    logic              nrst;
    logic [N-1:0]      req_valid;
    logic [N-1:0][4:0] req_sel;
    logic [N-1:0][31:0] req_dat;
    logic [N-1:0]      req_ready;
    logic              hold;
    logic              wen;
    logic [4:0]        wsel;
    logic [31:0]       wdat;
    logic              pend_valid;
    logic [4:0]        pend_sel;

    int checks = 0;
    int failures = 0;
    int unsigned exp_gnt[$];
    logic [36:0] exp_wr[$];
    int unsigned g_exp;
    logic [36:0] w_exp;

    rf_wb_arbiter #(.NUM_REQ(N), .REG_W(5), .WORD_W(32)) dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_sel(req_sel), .req_dat(req_dat),
        .req_ready(req_ready), .hold(hold), .wen(wen), .wsel(wsel), .wdat(wdat),
        .pend_valid(pend_valid), .pend_sel(pend_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (nrst === 1'b1) begin
            checks++;
            if ((req_ready & ~req_valid) != '0) begin
                failures++;
                $display("FAIL ready_without_valid got=%b valid=%b", req_ready, req_valid);
            end
            if (req_ready != '0) begin
                checks++;
                if (exp_gnt.size() == 0) begin
                    failures++;
                    $display("FAIL grant_unexpected got=%b want=none", req_ready);
                end else begin
                    g_exp = exp_gnt.pop_front();
                    if (req_ready != (N'(1) << g_exp)) begin
                        failures++;
                        $display("FAIL grant got=%b want=%b", req_ready, N'(1) << g_exp);
                    end
                end
            end
            if (wen) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    failures++;
                    $display("FAIL write_unexpected got=%0d:%h want=none", wsel, wdat);
                end else begin
                    w_exp = exp_wr.pop_front();
                    if ({wsel, wdat} != w_exp) begin
                        failures++;
                        $display("FAIL write got=%0d:%h want=%0d:%h", wsel, wdat, w_exp[36:32], w_exp[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        nrst = 1'b0;
        hold = 1'b0;
        req_valid = 3'b111;
        req_sel[0] = 5'd1; req_dat[0] = 32'hA1;
        req_sel[1] = 5'd2; req_dat[1] = 32'hA2;
        req_sel[2] = 5'd3; req_dat[2] = 32'hA3;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_wen", 64'(wen), 64'(0));
        chk("rst_pend", 64'(pend_valid), 64'(0));
        step();
        for (int i = 0; i < 6; i++) begin
`ifdef RF_WB_FIXED_PRIO_EN
            exp_gnt.push_back(0);
            exp_wr.push_back({5'd1, 32'hA1});
`else
            exp_gnt.push_back(i % 3);
            exp_wr.push_back({5'(i % 3 + 1), 32'hA1 + 32'(i % 3)});
`endif
        end
        nrst = 1'b1;
        repeat (6) step();
        req_valid = '0;
        step();

        exp_gnt.push_back(1);
        exp_wr.push_back({5'd5, 32'hDEADBEEF});
        req_sel[1] = 5'd5; req_dat[1] = 32'hDEADBEEF;
        req_valid = 3'b010;
        step();
        req_valid = '0;
        @(negedge clk);
        chk("single_wen", 64'(wen), 64'(1));
        chk("single_pend_valid", 64'(pend_valid), 64'(1));
        chk("single_pend_sel", 64'(pend_sel), 64'(5));
        step();

        exp_gnt.push_back(0);
        req_sel[0] = 5'd0; req_dat[0] = 32'h1234;
        req_valid = 3'b001;
        step();
        req_valid = '0;
        @(negedge clk);
        chk("x0_wen", 64'(wen), 64'(0));
        chk("x0_pend", 64'(pend_valid), 64'(0));
        step();

        req_sel[0] = 5'd9;  req_dat[0] = 32'h99;
        req_sel[1] = 5'd10; req_dat[1] = 32'h1010;
`ifdef RF_WB_FIXED_PRIO_EN
        exp_gnt.push_back(0); exp_wr.push_back({5'd9, 32'h99});
        exp_gnt.push_back(0); exp_wr.push_back({5'd9, 32'h99});
`else
        exp_gnt.push_back(1); exp_wr.push_back({5'd10, 32'h1010});
        exp_gnt.push_back(0); exp_wr.push_back({5'd9, 32'h99});
`endif
        req_valid = 3'b011;
        repeat (2) step();
        req_valid = '0;
        step();

        exp_gnt.push_back(2);
        exp_wr.push_back({5'd7, 32'h77});
        req_sel[2] = 5'd7; req_dat[2] = 32'h77;
        req_valid = 3'b100;
        step();
        hold = 1'b1;
        req_sel[0] = 5'd8; req_dat[0] = 32'h88;
        req_valid = 3'b001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_wen", 64'(wen), 64'(0));
            chk("hold_ready", 64'(req_ready), 64'(0));
            chk("hold_pend_sel", 64'(pend_sel), 64'(7));
            chk("hold_pend_valid", 64'(pend_valid), 64'(1));
            step();
        end
        exp_gnt.push_back(0);
        exp_wr.push_back({5'd8, 32'h88});
        hold = 1'b0;
        @(negedge clk);
        chk("release_wen", 64'(wen), 64'(1));
        chk("release_wsel", 64'(wsel), 64'(7));
        chk("release_ready", 64'(req_ready), 64'(3'b001));
        step();
        req_valid = '0;
        repeat (2) step();

        exp_gnt.push_back(1);
        req_sel[1] = 5'd11; req_dat[1] = 32'hBB;
        req_valid = 3'b010;
        step();
        hold = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("rsthold_pend_before", 64'(pend_valid), 64'(1));
        #1 nrst = 1'b0;
        #1;
        chk("rsthold_pend_after", 64'(pend_valid), 64'(0));
        chk("rsthold_wen", 64'(wen), 64'(0));
        #1 nrst = 1'b1;
        repeat (2) step();
        hold = 1'b0;
        step();

        exp_gnt.push_back(0);
        exp_wr.push_back({5'd13, 32'hD});
        req_sel[0] = 5'd13; req_dat[0] = 32'hD;
        req_sel[1] = 5'd14; req_dat[1] = 32'hE;
        req_valid = 3'b011;
        step();
        req_valid = '0;
        repeat (2) step();

        exp_gnt.push_back(2);
        exp_wr.push_back({5'd12, 32'hC});
        hold = 1'b1;
        req_sel[2] = 5'd12; req_dat[2] = 32'hC;
        req_valid = 3'b100;
        step();
        @(negedge clk);
        chk("empty_hold_pend", 64'(pend_valid), 64'(1));
        chk("empty_hold_wen", 64'(wen), 64'(0));
        chk("empty_hold_ready", 64'(req_ready), 64'(0));
        step();
        req_valid = '0;
        hold = 1'b0;
        @(negedge clk);
        chk("empty_hold_release_wen", 64'(wen), 64'(1));
        repeat (2) step();

        chk("gnt_queue_empty", 64'(exp_gnt.size()), 64'(0));
        chk("wr_queue_empty", 64'(exp_wr.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
